// File: rtl/utils_top_pkg.sv
//------------------------------------------------------------------------------
// Module   : utils_top (package)
// Purpose  : Shared opcode/funct encodings and M-extension FSM state type.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package utils_top;

    localparam logic [6:0] OP_OP         = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [5:0] MD_LAST_STEP = 6'd31;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MUL  = 2'd1,
        MD_DIV  = 2'd2,
        MD_DONE = 2'd3
    } md_state_t;

endpackage

`default_nettype wire

// File: rtl/execute_muldiv_step.sv
//------------------------------------------------------------------------------
// Module   : execute_muldiv_step
// Purpose  : One radix-2 shift-add (multiply) or restoring (divide) iteration.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module execute_muldiv_step (
    input  logic        i_div,
    input  logic [63:0] i_acc,
    input  logic [31:0] i_opb,
    output logic [63:0] o_acc
);

    logic [32:0] w_sum;
    logic [32:0] w_rem_sh;
    logic [32:0] w_diff;

    // Multiply: {hi, multiplier}; divide: {remainder, dividend/quotient}.
    always_comb begin
        w_sum    = {1'b0, i_acc[63:32]} + (i_acc[0] ? {1'b0, i_opb} : 33'd0);
        w_rem_sh = {i_acc[63:32], i_acc[31]};
        w_diff   = w_rem_sh - {1'b0, i_opb};
        o_acc    = {w_sum, i_acc[31:1]};
        if (i_div) begin
            if (w_diff[32]) begin
                o_acc = {w_rem_sh[31:0], i_acc[30:0], 1'b0};
            end else begin
                o_acc = {w_diff[31:0], i_acc[30:0], 1'b1};
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/execute_muldiv_seq.sv
//------------------------------------------------------------------------------
// Module   : execute_muldiv_seq
// Purpose  : Sequential RV32M multiply/divide unit for the execute stage.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module execute_muldiv_seq
    import utils_top::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [31:0] id_inst,
    input  logic [31:0] id_dat_a,
    input  logic [31:0] id_dat_b,
    input  logic        ex_kill,
    output logic        ex_md_stall,
    output logic        ex_md_done,
    output logic [31:0] ex_md_dat,
    output logic        ex_md_busy
);

    md_state_t   r_state;
    md_state_t   w_state_nxt;
    logic [63:0] r_acc;
    logic [31:0] r_b;
    logic [2:0]  r_f3;
    logic [5:0]  r_cnt;
    logic        r_neg_a;
    logic        r_neg_res;
    logic        r_fast;

    logic        w_req;
    logic [2:0]  w_f3;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic        w_dz;
    logic        w_ovf;
    logic        w_fast;
    logic [63:0] w_step_acc;
    logic [63:0] w_prod;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic [31:0] w_result;
    logic        w_unused_bits;

    assign w_unused_bits = ^{id_inst[24:15], id_inst[11:7]};

    assign w_f3  = id_inst[14:12];
    assign w_req = rst_n && id_valid && (id_inst[6:0] == OP_OP)
                   && (id_inst[31:25] == FUNCT7_MULDIV);

    // rs1 is signed for MUL/MULH/MULHSU/DIV/REM; rs2 for MUL/MULH/DIV/REM.
    assign w_a_neg = id_dat_a[31] && ((w_f3[2] && !w_f3[0]) || (!w_f3[2] && w_f3 != F3_MULHU));
    assign w_b_neg = id_dat_b[31] && ((w_f3[2] && !w_f3[0]) || w_f3 == F3_MUL || w_f3 == F3_MULH);
    assign w_a_mag = w_a_neg ? (32'd0 - id_dat_a) : id_dat_a;
    assign w_b_mag = w_b_neg ? (32'd0 - id_dat_b) : id_dat_b;

    assign w_dz   = w_f3[2] && (id_dat_b == 32'd0);
    assign w_ovf  = w_f3[2] && !w_f3[0] && (id_dat_a == 32'h8000_0000)
                    && (id_dat_b == 32'hFFFF_FFFF);
    assign w_fast = w_dz || w_ovf;

    execute_muldiv_step u_step (
        .i_div (r_state == MD_DIV),
        .i_acc (r_acc),
        .i_opb (r_b),
        .o_acc (w_step_acc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= MD_IDLE;
            r_acc     <= 64'd0;
            r_b       <= 32'd0;
            r_f3      <= 3'd0;
            r_cnt     <= 6'd0;
            r_neg_a   <= 1'b0;
            r_neg_res <= 1'b0;
            r_fast    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                MD_IDLE: begin
                    r_cnt <= 6'd0;
                    if (w_req && !ex_kill) begin
                        r_f3      <= w_f3;
                        r_b       <= w_b_mag;
                        r_neg_a   <= w_a_neg;
                        r_neg_res <= w_a_neg ^ w_b_neg;
                        r_fast    <= w_fast;
                        // Fast path preloads the final {remainder, quotient}.
                        if (w_dz) begin
                            r_acc <= {id_dat_a, 32'hFFFF_FFFF};
                        end else if (w_ovf) begin
                            r_acc <= {32'd0, 32'h8000_0000};
                        end else begin
                            r_acc <= {32'd0, w_a_mag};
                        end
                    end
                end
                MD_MUL, MD_DIV: begin
                    r_acc <= w_step_acc;
                    r_cnt <= r_cnt + 6'd1;
                end
                default: r_cnt <= 6'd0;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        ex_md_stall = 1'b0;
        if (ex_kill) begin
            w_state_nxt = MD_IDLE;
        end else begin
            case (r_state)
                MD_IDLE: begin
                    if (w_req) begin
                        ex_md_stall = 1'b1;
                        if (w_fast) begin
                            w_state_nxt = MD_DONE;
                        end else if (w_f3[2]) begin
                            w_state_nxt = MD_DIV;
                        end else begin
                            w_state_nxt = MD_MUL;
                        end
                    end
                end
                MD_MUL, MD_DIV: begin
                    ex_md_stall = 1'b1;
                    if (r_cnt == MD_LAST_STEP) begin
                        w_state_nxt = MD_DONE;
                    end
                end
                default: w_state_nxt = MD_IDLE;
            endcase
        end
    end

    assign w_prod = r_neg_res ? (64'd0 - r_acc) : r_acc;
    assign w_quo  = r_neg_res ? (32'd0 - r_acc[31:0]) : r_acc[31:0];
    assign w_rem  = r_neg_a ? (32'd0 - r_acc[63:32]) : r_acc[63:32];

    always_comb begin
        w_result = 32'd0;
        case (r_f3)
            F3_MUL:                       w_result = w_prod[31:0];
            F3_MULH, F3_MULHSU, F3_MULHU: w_result = w_prod[63:32];
            F3_DIV, F3_DIVU:              w_result = r_fast ? r_acc[31:0] : w_quo;
            default:                      w_result = r_fast ? r_acc[63:32] : w_rem;
        endcase
    end

    assign ex_md_done = (r_state == MD_DONE) && !ex_kill;
    assign ex_md_dat  = ex_md_done ? w_result : 32'd0;
    assign ex_md_busy = (r_state != MD_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_execute_muldiv_seq.sv
//------------------------------------------------------------------------------
// Module   : tb_execute_muldiv_seq
// Purpose  : Self-checking bench for execute_muldiv_seq against an arithmetic model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_execute_muldiv_seq;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_dat_a;
    logic [31:0] id_dat_b;
    logic        ex_kill;
    logic        ex_md_stall;
    logic        ex_md_done;
    logic [31:0] ex_md_dat;
    logic        ex_md_busy;

    int checks = 0;
    int errors = 0;

    execute_muldiv_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_inst     (id_inst),
        .id_dat_a    (id_dat_a),
        .id_dat_b    (id_dat_b),
        .ex_kill     (ex_kill),
        .ex_md_stall (ex_md_stall),
        .ex_md_done  (ex_md_done),
        .ex_md_dat   (ex_md_dat),
        .ex_md_busy  (ex_md_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [31:0] mk_inst(input logic [6:0] f7, input logic [2:0] f3);
        logic [4:0] rs1, rs2, rd;
        rs1 = 5'($urandom_range(0, 31));
        rs2 = 5'($urandom_range(0, 31));
        rd  = 5'($urandom_range(0, 31));
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic is_fast(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        return f3[2] && ((b == 32'd0) ||
               (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    // RV32M semantics from plain integer arithmetic.
    function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        logic [31:0] r;
        int sa, sb;
        logic ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        r   = 32'd0;
        case (f3)
            3'd0: begin p = {32'd0, a} * {32'd0, b}; r = p[31:0]; end
            3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; r = p[63:32]; end
            3'd2: begin p = {{32{a[31]}}, a} * {32'd0, b}; r = p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
            3'd4: r = (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: r = (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_v);
        int lat;
        lat = is_fast(f3, a, b) ? 1 : 33;
        next_cycle();
        id_valid = 1'b1;
        id_inst  = mk_inst(7'b0000001, f3);
        id_dat_a = a;
        id_dat_b = b;
        #1;
        check({tag, "_stall_T"}, 32'(ex_md_stall), 32'd1);
        for (int k = 1; k <= lat; k++) begin
            next_cycle();
            id_dat_a = $urandom;
            id_dat_b = $urandom;
            #1;
            if (k < lat) begin
                check({tag, "_stall_run"}, 32'(ex_md_stall), 32'd1);
                check({tag, "_done_early"}, 32'(ex_md_done), 32'd0);
                check({tag, "_dat_idle"}, ex_md_dat, 32'd0);
            end else begin
                check({tag, "_done"}, 32'(ex_md_done), 32'd1);
                check({tag, "_stall_done"}, 32'(ex_md_stall), 32'd0);
                check({tag, "_dat"}, ex_md_dat, exp_v);
            end
        end
        next_cycle();
        id_valid = 1'b0;
        #1;
        check({tag, "_busy_after"}, 32'(ex_md_busy), 32'd0);
        check({tag, "_done_after"}, 32'(ex_md_done), 32'd0);
    endtask

    initial begin
        int pulses;
        logic [2:0]  f3;
        logic [31:0] a, b;

        rst_n    = 1'b0;
        id_valid = 1'b0;
        id_inst  = 32'd0;
        id_dat_a = 32'd0;
        id_dat_b = 32'd0;
        ex_kill  = 1'b0;
        repeat (3) next_cycle();
        #1;
        check("rst_stall", 32'(ex_md_stall), 32'd0);
        check("rst_done", 32'(ex_md_done), 32'd0);
        check("rst_busy", 32'(ex_md_busy), 32'd0);
        check("rst_dat", ex_md_dat, 32'd0);
        next_cycle();
        rst_n = 1'b1;

        // Directed values
        run_op("mul_neg", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        run_op("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("mulh_m1", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
        run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("divu_z", 3'd5, 32'd100, 32'd0, 32'hFFFF_FFFF);
        run_op("remu_z", 3'd7, 32'd100, 32'd0, 32'd100);
        run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        run_op("rem_neg", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run_op("div_neg", 3'd4, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2);
        run_op("rem_dz_s", 3'd6, 32'hFFFF_FF00, 32'd0, 32'hFFFF_FF00);

        // Non-M instruction must not stall
        next_cycle();
        id_valid = 1'b1;
        id_inst  = mk_inst(7'b0000000, 3'd0);
        #1;
        check("nonm_stall", 32'(ex_md_stall), 32'd0);
        next_cycle();
        id_valid = 1'b0;
        #1;
        check("nonm_busy", 32'(ex_md_busy), 32'd0);

        // Kill beats a request in IDLE
        next_cycle();
        id_valid = 1'b1;
        id_inst  = mk_inst(7'b0000001, 3'd0);
        ex_kill  = 1'b1;
        #1;
        check("kill_idle_stall", 32'(ex_md_stall), 32'd0);
        next_cycle();
        ex_kill  = 1'b0;
        id_valid = 1'b0;
        #1;
        check("kill_idle_busy", 32'(ex_md_busy), 32'd0);

        // Kill mid-divide at T+10
        next_cycle();
        id_valid = 1'b1;
        id_inst  = mk_inst(7'b0000001, 3'd4);
        id_dat_a = 32'd1000;
        id_dat_b = 32'd7;
        repeat (9) next_cycle();
        #1;
        check("kill_pre_stall", 32'(ex_md_stall), 32'd1);
        next_cycle();
        ex_kill = 1'b1;
        #1;
        check("kill_stall", 32'(ex_md_stall), 32'd0);
        check("kill_done", 32'(ex_md_done), 32'd0);
        next_cycle();
        ex_kill  = 1'b0;
        id_valid = 1'b0;
        #1;
        check("kill_busy", 32'(ex_md_busy), 32'd0);
        check("kill_done2", 32'(ex_md_done), 32'd0);
        run_op("after_kill", 3'd0, 32'd3, 32'd5, 32'd15);

        // Reset at T+5 of a multiply
        next_cycle();
        id_valid = 1'b1;
        id_inst  = mk_inst(7'b0000001, 3'd0);
        id_dat_a = 32'd9;
        id_dat_b = 32'd9;
        repeat (5) next_cycle();
        rst_n = 1'b0;
        next_cycle();
        rst_n    = 1'b1;
        id_valid = 1'b0;
        #1;
        check("mrst_stall", 32'(ex_md_stall), 32'd0);
        check("mrst_done", 32'(ex_md_done), 32'd0);
        check("mrst_busy", 32'(ex_md_busy), 32'd0);
        check("mrst_dat", ex_md_dat, 32'd0);
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            next_cycle();
            #1;
            if (ex_md_done || ex_md_busy) pulses++;
        end
        check("mrst_quiet", 32'(pulses), 32'd0);
        run_op("after_rst", 3'd3, 32'h1234_5678, 32'h9ABC_DEF0, ref_md(3'd3, 32'h1234_5678, 32'h9ABC_DEF0));

        // Randomized operations against the model
        for (int n = 0; n < 32; n++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 5) == 0) b = 32'd0;
            if ($urandom_range(0, 7) == 0) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 15));
            run_op("rand", f3, a, b, ref_md(f3, a, b));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/execute_muldiv_seq.md
EXECUTE_MULDIV_SEQ -- requirements
Module: execute_muldiv_seq

Interface
REQ-001 SHALL have port clk, input, 1, the single core clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-003 SHALL have port id_valid, input, 1, the execute-stage instruction is valid (not a bubble).
REQ-004 SHALL have port id_inst, input, 32, the execute-stage instruction.
REQ-005 SHALL have port id_dat_a, input, 32, rs1 operand (already forwarded).
REQ-006 SHALL have port id_dat_b, input, 32, rs2 operand (already forwarded).
REQ-007 SHALL have port ex_kill, input, 1, abort of the in-flight operation (younger-instruction flush).
REQ-008 SHALL have port ex_md_stall, output, 1, hold fetch/decode/execute registers this cycle.
REQ-009 SHALL have port ex_md_done, output, 1, one-cycle pulse; ex_md_dat valid this cycle.
REQ-010 SHALL have port ex_md_dat, output, 32, M-extension result, selected over the ALU output when ex_md_done=1.
REQ-011 SHALL have port ex_md_busy, output, 1, FSM not in IDLE (debug/perf visibility).

Function
REQ-012 SHALL detect a request when id_valid=1, opcode=OP_OP (0110011), funct7=0000001; funct3 selects MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
REQ-013 SHALL implement FSM states IDLE, MUL, DIV, DONE.
REQ-014 IDLE: on request at cycle T, latch operands, funct3, and operand signs; assert ex_md_stall combinationally in T; go to MUL (funct3[2]=0) or DIV (funct3[2]=1).
REQ-015 SHALL take the fast path for a divide with divisor 0 or signed overflow (0x80000000 / 0xFFFFFFFF): IDLE -> DONE, with result valid at T+1.
REQ-016 MUL/DIV: perform one radix-2 step per cycle on unsigned magnitudes using a 6-bit counter; exactly 32 steps, in cycles T+1..T+32; the state after the 32nd step is DONE.
REQ-017 MUL: shift-add into a 64-bit accumulator; MUL returns the low 32 bits; MULH/MULHSU/MULHU return the high 32 bits after sign correction by operand signedness (MULHSU: rs1 signed, rs2 unsigned).
REQ-018 DIV: restoring division producing a 32-bit quotient and remainder; quotient is negated when operand signs differ (signed ops); remainder takes the dividend's sign.
REQ-019 Divide by zero: quotient=0xFFFFFFFF, remainder=dividend. Signed overflow: quotient=0x80000000, remainder=0.
REQ-020 DONE (cycle T+33, or T+1 on the fast path): ex_md_done=1, ex_md_stall=0, ex_md_dat valid; next state is IDLE unconditionally.
REQ-021 ex_md_stall SHALL be 1 in IDLE-with-request, MUL, and DIV, and 0 otherwise.
REQ-022 ex_kill=1 in any state SHALL force IDLE next cycle, suppress ex_md_done, and drop ex_md_stall in that same cycle; ex_kill has priority over a request and over DONE.
REQ-023 A request present in DONE belongs to the completing instruction and SHALL NOT restart the FSM; back-to-back M instructions start from IDLE at T+34.
REQ-024 ex_md_dat SHALL hold 0 whenever ex_md_done=0.
REQ-025 Operand inputs SHALL be ignored outside IDLE; latched copies are used throughout.

Reset
REQ-026 With rst_n=0 at a clock edge: state=IDLE, counter=0, accumulator and operand registers=0; ex_md_stall, ex_md_done, ex_md_busy, ex_md_dat=0 in the following cycle.
REQ-027 Reset asserted mid-operation SHALL abandon it with no ex_md_done pulse; the stall releases the cycle after reset is sampled.

Structure
REQ-028 OP_OP, FUNCT7_MULDIV, the eight funct3 encodings, and the md_state_t enum SHALL reside in the shared utils_top package.
REQ-029 A single sub-module, execute_muldiv_step, SHALL implement one combinational add/subtract-shift iteration; sign magnitude conversion and correction stay in the top.

Verification
REQ-030 MUL 7 x 0xFFFFFFFD requested at T -> stall during T..T+32; done at T+33 with ex_md_dat=0xFFFFFFEB.
REQ-031 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> ex_md_dat=0xFFFFFFFE at T+33; MULH of the same operands -> 0x00000000.
REQ-032 DIVU 100 / 0 -> done at T+1, ex_md_dat=0xFFFFFFFF; REMU 100 / 0 -> 100 at T+1.
REQ-033 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 at T+1; REM of the same operands -> 0; REM 0xFFFFFFF9 / 2 -> 0xFFFFFFFF at T+33.
REQ-034 DIV started at T with ex_kill=1 at T+10 -> stall=0 at T+10, IDLE at T+11, no done pulse; a new MUL at T+12 completes at T+45.
REQ-035 rst_n=0 at T+5 of a MUL -> all outputs 0 from T+6 with no done pulse; a subsequent request operates normally.
